dma_axi_responder: RTL

- AXI4 slave responder: the other end of the DMA master's read/write bursts.
- Accepts one transaction at a time (read or write), serves it from an internal word-addressed SRAM array, and returns B/R responses with the ID echoed.
- Used as the DMA bench target and as the on-chip scratch memory behind the bus.

---
 rtl/dma_axi_responder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dma_axi_responder.sv
// rtl/dma_axi_responder.sv - single-outstanding AXI4 burst responder over a word SRAM
// Optional per-beat address range check: define DMA_RESP_ADDR_CHECK_EN.
module dma_axi_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int AW = $clog2(DEPTH);
`ifdef DMA_RESP_ADDR_CHECK_EN
  localparam int OW = 30;
`else
  localparam int OW = AW;
`endif
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic [3:0] id_q, id_d, len_q, len_d, beat_q, beat_d;
  logic [OW-1:0] off_q, off_d;
  logic fixed_q, fixed_d, err_q, err_d;
  logic awready_q, awready_d, arready_q, arready_d, wready_q, wready_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [3:0] bid_q, bid_d, rid_q, rid_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] aw_diff, ar_diff, mem_rdata;
  logic [OW-1:0] aw_off, ar_off;
  logic [AW-1:0] rd_idx;
  logic ar_oor, cur_oor, err_n, last_beat, mem_we;

  assign aw_diff = awaddr - BASE_ADDR;
  assign ar_diff = araddr - BASE_ADDR;
  assign aw_off  = aw_diff[OW+1:2];
  assign ar_off  = ar_diff[OW+1:2];
`ifdef DMA_RESP_ADDR_CHECK_EN
  assign ar_oor  = (ar_off >= OW'(DEPTH));
  assign cur_oor = (off_q >= OW'(DEPTH));
`else
  assign ar_oor  = 1'b0;
  assign cur_oor = 1'b0;
`endif
  // The first read beat is fetched on the AR handshake edge, before off_q holds the start index.
  assign rd_idx    = (state_q == IDLE) ? ar_off[AW-1:0] : off_q[AW-1:0];
  assign mem_rdata = mem[rd_idx];

  always_comb begin
    state_d = state_q; last_grant_d = last_grant_q;
    id_d = id_q; len_d = len_q; beat_d = beat_q; off_d = off_q;
    fixed_d = fixed_q; err_d = err_q;
    awready_d = 1'b0; arready_d = 1'b0; wready_d = wready_q;
    bvalid_d = bvalid_q; bid_d = bid_q; bresp_d = bresp_q;
    rvalid_d = rvalid_q; rid_d = rid_q; rdata_d = rdata_q; rresp_d = rresp_q; rlast_d = rlast_q;
    err_n = err_q; last_beat = (beat_q == len_q); mem_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (awready_q && awvalid) begin
          id_d = awid; off_d = aw_off; len_d = awlen; beat_d = 4'd0;
          fixed_d = (awburst == 2'b00);
          err_d = (awsize != 3'b010) || awburst[1];
          wready_d = 1'b1; last_grant_d = 1'b1; state_d = WRITE;
        end else if (arready_q && arvalid) begin
          err_n = (arsize != 3'b010) || arburst[1] || ar_oor;
          id_d = arid; len_d = arlen; beat_d = 4'd0; fixed_d = (arburst == 2'b00);
          off_d = ar_off + {{(OW-1){1'b0}}, (arburst != 2'b00)};
          err_d = err_n; rid_d = arid; rvalid_d = 1'b1; rlast_d = (arlen == 4'd0);
          rdata_d = err_n ? 32'd0 : mem_rdata;
          rresp_d = err_n ? RESP_SLVERR : RESP_OKAY;
          last_grant_d = 1'b0; state_d = READ;
        end else begin
          // On a collision the channel that lost the previous grant goes first.
          awready_d = awvalid && (!arvalid || !last_grant_q);
          arready_d = arvalid && !awready_d;
        end
      end
      WRITE: begin
        if (wvalid && wready_q) begin
          mem_we = !(err_q || cur_oor);
          err_n = err_q || cur_oor || (wlast != last_beat);
          err_d = err_n;
          off_d = off_q + {{(OW-1){1'b0}}, !fixed_q};
          beat_d = beat_q + 4'd1;
          if (last_beat) begin
            wready_d = 1'b0; bvalid_d = 1'b1; bid_d = id_q;
            bresp_d = err_n ? RESP_SLVERR : RESP_OKAY;
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (bready) begin
          bvalid_d = 1'b0; state_d = IDLE;
        end
      end
      READ: begin
        if (rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0; rlast_d = 1'b0; state_d = IDLE;
          end else begin
            err_n = err_q || cur_oor; err_d = err_n;
            rdata_d = err_n ? 32'd0 : mem_rdata;
            rresp_d = err_n ? RESP_SLVERR : RESP_OKAY;
            beat_d = beat_q + 4'd1;
            rlast_d = (4'(beat_q + 4'd1) == len_q);
            off_d = off_q + {{(OW-1){1'b0}}, !fixed_q};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE; last_grant_q <= 1'b0;
      id_q <= '0; len_q <= '0; beat_q <= '0; off_q <= '0; fixed_q <= 1'b0; err_q <= 1'b0;
      awready_q <= 1'b0; arready_q <= 1'b0; wready_q <= 1'b0;
      bvalid_q <= 1'b0; bid_q <= '0; bresp_q <= '0;
      rvalid_q <= 1'b0; rid_q <= '0; rdata_q <= '0; rresp_q <= '0; rlast_q <= 1'b0;
    end else begin
      state_q <= state_d; last_grant_q <= last_grant_d;
      id_q <= id_d; len_q <= len_d; beat_q <= beat_d; off_q <= off_d; fixed_q <= fixed_d; err_q <= err_d;
      awready_q <= awready_d; arready_q <= arready_d; wready_q <= wready_d;
      bvalid_q <= bvalid_d; bid_q <= bid_d; bresp_q <= bresp_d;
      rvalid_q <= rvalid_d; rid_q <= rid_d; rdata_q <= rdata_d; rresp_q <= rresp_d; rlast_q <= rlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[off_q[AW-1:0]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign arready = arready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule
